// File: rtl/bram_frame_buffer_if.sv
// Interface: bram_frame_buffer_if
//
// Groups the request/response signals of bram_frame_buffer. The master modport is the
// client side, which includes the pixel writer, the window readers and the clear control.
// The slave modport is the RAM side.
//
// Signals:
//   clear_req  master->slave  pulse: start background clear
//   busy       slave->master  clear FSM active
//   wr_en      master->slave  write strobe
//   wr_addr    master->slave  write address
//   din        master->slave  write data
//   wr_drop    slave->master  1-cycle pulse: write discarded
//   rd_en      master->slave  read strobe
//   rd_addr    master->slave  read address
//   rd_valid   slave->master  dout valid
//   dout       slave->master  read data
//   addr_err   slave->master  1-cycle pulse with rd_valid: read address out of range
interface bram_frame_buffer_if #(
    parameter int unsigned BRAM_DATA_WIDTH = 12,
    parameter int unsigned BRAM_ADDR_WIDTH = 19
);
    logic                       clear_req;
    logic                       busy;
    logic                       wr_en;
    logic [BRAM_ADDR_WIDTH-1:0] wr_addr;
    logic [BRAM_DATA_WIDTH-1:0] din;
    logic                       wr_drop;
    logic                       rd_en;
    logic [BRAM_ADDR_WIDTH-1:0] rd_addr;
    logic                       rd_valid;
    logic [BRAM_DATA_WIDTH-1:0] dout;
    logic                       addr_err;

    modport master (
        output clear_req, wr_en, wr_addr, din, rd_en, rd_addr,
        input  busy, wr_drop, rd_valid, dout, addr_err
    );

    modport slave (
        input  clear_req, wr_en, wr_addr, din, rd_en, rd_addr,
        output busy, wr_drop, rd_valid, dout, addr_err
    );
endinterface

// File: rtl/bram_frame_buffer.sv
// Module: bram_frame_buffer
//
// Single-clock frame buffer RAM with a registered read (1 or 2 cycle latency), a
// selectable read-during-write behaviour and a background clear FSM that writes
// CLEAR_VALUE to one word per cycle. The array itself has no reset; after reset the
// FSM clears it, and busy stays high until the last word has been written.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset
//   bus    slave modport of bram_frame_buffer_if (clear, write, read channels)
module bram_frame_buffer #(
    parameter int unsigned                BRAM_BUFFER_SIZE = 388800,
    parameter int unsigned                BRAM_DATA_WIDTH  = 12,
    parameter int unsigned                BRAM_ADDR_WIDTH  = 19,
    parameter int unsigned                RD_LATENCY       = 1,
    parameter int unsigned                RDW_MODE         = 0,
    parameter logic [BRAM_DATA_WIDTH-1:0] CLEAR_VALUE      = '0
) (
    input  logic               clock,
    input  logic               reset,
    bram_frame_buffer_if.slave bus
);
    // Index width of the array; addresses are range-checked before being sliced to it.
    localparam int unsigned IdxWidth =
        (BRAM_BUFFER_SIZE > 1) ? $clog2(BRAM_BUFFER_SIZE) : 1;
    localparam logic [BRAM_ADDR_WIDTH-1:0] SizeAddr = BRAM_ADDR_WIDTH'(BRAM_BUFFER_SIZE);
    localparam logic [BRAM_ADDR_WIDTH-1:0] LastAddr = BRAM_ADDR_WIDTH'(BRAM_BUFFER_SIZE - 1);
    // When SIZE fills the whole address space SizeAddr wraps to 0, so every address is legal.
    localparam bit FullRange =
        (longint'(BRAM_BUFFER_SIZE) >= (longint'(1) << BRAM_ADDR_WIDTH));
    localparam bit WriteFirst = (RDW_MODE == 1);

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                       wr_drop_q;

    logic [BRAM_DATA_WIDTH-1:0] mem [BRAM_BUFFER_SIZE];

    logic                       busy;
    logic                       wr_in_range;
    logic                       rd_in_range;
    logic                       mem_we;
    logic [BRAM_ADDR_WIDTH-1:0] mem_waddr;
    logic [BRAM_DATA_WIDTH-1:0] mem_wdata;
    logic                       rd_hit;

    logic                       valid1_q;
    logic                       err1_q;
    logic [BRAM_DATA_WIDTH-1:0] dout1_q;

    assign busy        = (state_q == StClear);
    assign wr_in_range = FullRange || (bus.wr_addr < SizeAddr);
    assign rd_in_range = FullRange || (bus.rd_addr < SizeAddr);

    // Clear FSM next state
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clear_req) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end
            end
            StClear: begin
                // clear_req is ignored here; the sweep is never restarted mid-way
                if (clr_addr_q == LastAddr) begin
                    state_d = StIdle;
                end else begin
                    clr_addr_d = clr_addr_q + BRAM_ADDR_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Single write port shared by the clear FSM and the user write channel
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.din;
        if (reset) begin
            mem_we = 1'b0;
        end else if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = CLEAR_VALUE;
        end else if (bus.wr_en && wr_in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_drop_q  <= bus.wr_en && (busy || !wr_in_range);
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr[IdxWidth-1:0]] <= mem_wdata;
        end
    end

    // Write-first bypass; covers both user writes and clear FSM writes
    assign rd_hit = WriteFirst && mem_we && (mem_waddr == bus.rd_addr);

    // First read register; the non-blocking array read gives read-first by default
    always_ff @(posedge clock) begin
        if (reset) begin
            valid1_q <= 1'b0;
            err1_q   <= 1'b0;
            dout1_q  <= '0;
        end else begin
            valid1_q <= bus.rd_en;
            err1_q   <= bus.rd_en && !rd_in_range;
            if (bus.rd_en) begin
                if (!rd_in_range) begin
                    dout1_q <= CLEAR_VALUE;
                end else if (rd_hit) begin
                    dout1_q <= mem_wdata;
                end else begin
                    dout1_q <= mem[bus.rd_addr[IdxWidth-1:0]];
                end
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                       valid2_q;
            logic                       err2_q;
            logic [BRAM_DATA_WIDTH-1:0] dout2_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    valid2_q <= 1'b0;
                    err2_q   <= 1'b0;
                    dout2_q  <= '0;
                end else begin
                    valid2_q <= valid1_q;
                    err2_q   <= err1_q;
                    if (valid1_q) begin
                        dout2_q <= dout1_q;
                    end
                end
            end

            assign bus.rd_valid = valid2_q;
            assign bus.addr_err = err2_q;
            assign bus.dout     = dout2_q;
        end else begin : g_lat1
            assign bus.rd_valid = valid1_q;
            assign bus.addr_err = err1_q;
            assign bus.dout     = dout1_q;
        end
    endgenerate

    assign bus.busy    = busy;
    assign bus.wr_drop = wr_drop_q;
endmodule
